// File: rtl/lc3_mem_pkg.sv
// Shared types and MMIO address map for the LC-3 style memory responder.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  // Status registers expose their single flag in bit 15
  function automatic logic [15:0] flag_word(input logic flag);
    return {flag, 15'h0000};
  endfunction

  function automatic logic [15:0] byte_word(input logic [7:0] b);
    return {8'h00, b};
  endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port 16-bit RAM: synchronous write, combinational read. Not reset.
module ram_sp #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [15:0] mem_q [0:DEPTH-1];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: wait-stated access to RAM plus keyboard/display MMIO,
// answering each CPU request with a one-cycle rsp_ready pulse.
module mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : {CNT_W{1'b0}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              kb_flag_q, kb_flag_d;
  logic [7:0]        kbd_q, kbd_d;
  logic              dsr_q, dsr_d;
  logic              disp_valid_q, disp_valid_d;
  logic [7:0]        disp_data_q, disp_data_d;
  logic              rsp_ready_q, rsp_ready_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;

  logic              acc_we;
  logic [15:0]       acc_addr;
  logic [15:0]       acc_wdata;
  logic              is_kbsr, is_kbdr, is_dsr, is_ddr, is_ram;
  logic              commit;
  logic              ram_we;
  logic [15:0]       ram_rdata;

  // The access in flight: live request while IDLE, latched copy afterwards
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  // Address decode and commit qualifier
  always_comb begin
    is_kbsr = (acc_addr == ADDR_KBSR);
    is_kbdr = (acc_addr == ADDR_KBDR);
    is_dsr  = (acc_addr == ADDR_DSR);
    is_ddr  = (acc_addr == ADDR_DDR);
    is_ram  = !(is_kbsr || is_kbdr || is_dsr || is_ddr);
    commit  = (state_q == RESP) && !rst;
    ram_we  = commit && acc_we && is_ram;
  end

  ram_sp #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (acc_addr[ADDR_W-1:0]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  // Access FSM, wait counter and request latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = {CNT_W{1'b0}};
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1'b1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Keyboard and display registers; a new key always wins over the KBDR read clear
  always_comb begin
    kb_flag_d    = kb_flag_q;
    kbd_d        = kbd_q;
    dsr_d        = dsr_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    if (kb_valid) begin
      kb_flag_d = 1'b1;
      kbd_d     = kb_data;
    end else if (commit && !acc_we && is_kbdr) begin
      kb_flag_d = 1'b0;
    end else begin
      kb_flag_d = kb_flag_q;
    end
    if (disp_valid_q && disp_ready) begin
      disp_valid_d = 1'b0;
      dsr_d        = 1'b1;
    end else if (commit && acc_we && is_ddr && dsr_q) begin
      disp_data_d  = acc_wdata[7:0];
      disp_valid_d = 1'b1;
      dsr_d        = 1'b0;
    end else begin
      dsr_d        = dsr_q;
    end
  end

  // Response is registered on entry to RESP using next-state register values,
  // so it matches exactly what the RESP cycle would observe
  always_comb begin
    rsp_ready_d = 1'b0;
    rsp_rdata_d = 16'h0000;
    if (state_d == RESP) begin
      rsp_ready_d = 1'b1;
      if (!acc_we) begin
        case (acc_addr)
          ADDR_KBSR: rsp_rdata_d = flag_word(kb_flag_d);
          ADDR_KBDR: rsp_rdata_d = byte_word(kbd_d);
          ADDR_DSR:  rsp_rdata_d = flag_word(dsr_d);
          ADDR_DDR:  rsp_rdata_d = byte_word(disp_data_d);
          default:   rsp_rdata_d = ram_rdata;
        endcase
      end else begin
        rsp_rdata_d = 16'h0000;
      end
    end else begin
      rsp_ready_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      kb_flag_q    <= 1'b0;
      kbd_q        <= 8'h00;
      dsr_q        <= 1'b1;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
      rsp_ready_q  <= 1'b0;
      rsp_rdata_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      kb_flag_q    <= kb_flag_d;
      kbd_q        <= kbd_d;
      dsr_q        <= dsr_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      rsp_ready_q  <= rsp_ready_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign rsp_ready  = rsp_ready_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic against a behavioural model of the memory map.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_valid0, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        kb_valid, disp_ready;
  logic [7:0]  kb_data;
  logic        rsp_ready, rsp_ready0, disp_valid, disp_valid0;
  logic [15:0] rsp_rdata, rsp_rdata0;
  logic [7:0]  disp_data, disp_data0;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [15:0] mem_m [int];
  bit          kb_flag_m, dsr_m, disp_valid_m;
  logic [7:0]  kbd_m, disp_data_m;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready));

  mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_valid(disp_valid0), .disp_data(disp_data0), .disp_ready(disp_ready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One CPU access; lat counts cycles from the accept edge to the rsp_ready cycle
  task automatic access(input bit sel0, input bit we, input logic [15:0] a,
                        input logic [15:0] wd, input bit kbv, input logic [7:0] kd,
                        output logic [15:0] rd, output int lat);
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd;
    if (sel0) req_valid0 = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    lat = 99;
    rd  = 16'hxxxx;
    for (int k = 1; k <= 8; k++) begin
      if (sel0 ? rsp_ready0 : rsp_ready) begin
        lat = k;
        rd  = sel0 ? rsp_rdata0 : rsp_rdata;
        break;
      end
      chk("rdata_while_waiting", sel0 ? rsp_rdata0 : rsp_rdata, 16'h0000);
      @(posedge clk); #1;
    end
    if (kbv) begin kb_valid = 1'b1; kb_data = kd; end
    @(negedge clk);
    req_valid = 1'b0; req_valid0 = 1'b0;
    @(posedge clk); #1;
    kb_valid = 1'b0;
    chk("rsp_ready_after_resp", sel0 ? rsp_ready0 : rsp_ready, 1'b0);
  endtask

  // Access on the WAIT_STATES=2 instance, checked against and applied to the model
  task automatic op(input bit we, input logic [15:0] a, input logic [15:0] wd,
                    input bit kbv, input logic [7:0] kd);
    logic [15:0] rd, exp_v;
    int lat;
    bit known;
    known = 1'b1;
    case (a)
      16'hFE00: exp_v = kb_flag_m ? 16'h8000 : 16'h0000;
      16'hFE02: exp_v = {8'h00, kbd_m};
      16'hFE04: exp_v = dsr_m ? 16'h8000 : 16'h0000;
      16'hFE06: exp_v = {8'h00, disp_data_m};
      default: begin
        known = mem_m.exists(int'(a % 16'd1024));
        exp_v = known ? mem_m[int'(a % 16'd1024)] : 16'h0000;
      end
    endcase
    if (we) exp_v = 16'h0000;
    access(1'b0, we, a, wd, kbv, kd, rd, lat);
    chk("latency", lat, 3);
    if (known) chk(we ? "write_rdata" : "read_rdata", rd, exp_v);
    if (we) begin
      if (a == 16'hFE06) begin
        if (dsr_m) begin disp_data_m = wd[7:0]; disp_valid_m = 1'b1; dsr_m = 1'b0; end
      end else if (a != 16'hFE00 && a != 16'hFE02 && a != 16'hFE04) begin
        mem_m[int'(a % 16'd1024)] = wd;
      end
    end else if (a == 16'hFE02 && !kbv) begin
      kb_flag_m = 1'b0;
    end
    if (kbv) begin kb_flag_m = 1'b1; kbd_m = kd; end
    chk("disp_valid", disp_valid, disp_valid_m);
    chk("disp_data", disp_data, disp_data_m);
  endtask

  task automatic kb_strobe(input logic [7:0] d);
    @(negedge clk); kb_valid = 1'b1; kb_data = d;
    @(negedge clk); kb_valid = 1'b0;
    kb_flag_m = 1'b1; kbd_m = d;
  endtask

  task automatic disp_pulse();
    @(negedge clk); disp_ready = 1'b1;
    @(negedge clk); disp_ready = 1'b0;
    if (disp_valid_m) begin disp_valid_m = 1'b0; dsr_m = 1'b1; end
    chk("disp_valid_handshake", disp_valid, disp_valid_m);
  endtask

  function automatic logic [15:0] ram_addr();
    logic [15:0] a;
    a = {6'($urandom), 10'($urandom_range(0, 15) * 61)};
    if (a[15:3] == 13'h1FC0) a[15] = 1'b0;
    return a;
  endfunction

  function automatic void model_reset();
    kb_flag_m = 1'b0; kbd_m = 8'h00; dsr_m = 1'b1;
    disp_valid_m = 1'b0; disp_data_m = 8'h00;
  endfunction

  initial begin
    logic [15:0] rd;
    int lat, pulses, r;
    rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_we = 1'b0;
    req_addr = 16'h0000; req_wdata = 16'h0000;
    kb_valid = 1'b0; kb_data = 8'h00; disp_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_ready", rsp_ready, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 16'h0000);
    chk("reset_disp_valid", disp_valid, 1'b0);
    chk("reset_disp_data", disp_data, 8'h00);
    chk("reset_rsp_ready0", rsp_ready0, 1'b0);
    @(negedge clk); rst = 1'b0;
    op(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);
    op(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);

    // RAM write then read
    op(1'b1, 16'h0010, 16'h1234, 1'b0, 8'h00);
    op(1'b0, 16'h0010, 16'h0000, 1'b0, 8'h00);

    // Keyboard
    kb_strobe(8'h41);
    op(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
    op(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);
    op(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);

    // Display: accepted write, dropped write, handshake
    op(1'b1, 16'hFE06, 16'h0058, 1'b0, 8'h00);
    chk("ddr_loaded", disp_data, 8'h58);
    op(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);
    op(1'b1, 16'hFE06, 16'h0077, 1'b0, 8'h00);
    op(1'b0, 16'hFE06, 16'h0000, 1'b0, 8'h00);
    disp_pulse();
    op(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);

    // Key arrives in the same cycle as the KBDR read response
    kb_strobe(8'h11);
    op(1'b0, 16'hFE02, 16'h0000, 1'b1, 8'h22);
    op(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
    op(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);

    // Reset while in WAIT aborts the write
    op(1'b1, 16'h0020, 16'h1111, 1'b0, 8'h00);
    @(negedge clk);
    req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'hBEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_wait", rsp_ready, 1'b0);
    @(negedge clk); rst = 1'b1; req_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (rsp_ready) pulses++;
      if (k == 0) rst = 1'b0;
    end
    chk("abort_no_pulse", pulses, 0);
    model_reset();
    op(1'b0, 16'h0020, 16'h0000, 1'b0, 8'h00);
    op(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: op(1'b1, ram_addr(), 16'($urandom), 1'b0, 8'h00);
        2, 3: op(1'b0, ram_addr(), 16'h0000, 1'b0, 8'h00);
        4:    kb_strobe(8'($urandom));
        5:    op(1'b0, 16'hFE00 + 16'($urandom_range(0, 3) * 2), 16'h0000, 1'b0, 8'h00);
        6:    op(1'b1, 16'hFE06, 16'($urandom), 1'b0, 8'h00);
        7:    disp_pulse();
        8:    op(1'b1, 16'hFE00 + 16'($urandom_range(0, 2) * 2), 16'($urandom), 1'b0, 8'h00);
        default: op(1'b0, 16'hFE02, 16'h0000, 1'($urandom), 8'($urandom));
      endcase
    end

    // Zero wait states
    kb_strobe(8'h5A);
    access(1'b1, 1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, rd, lat);
    chk("ws0_latency_read", lat, 1);
    chk("ws0_kbsr_before", rd, 16'h8000);
    access(1'b1, 1'b1, 16'hFE00, 16'h0000, 1'b0, 8'h00, rd, lat);
    chk("ws0_latency_write", lat, 1);
    chk("ws0_write_rdata", rd, 16'h0000);
    access(1'b1, 1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, rd, lat);
    chk("ws0_kbsr_after", rd, 16'h8000);
    access(1'b1, 1'b1, 16'h0123, 16'hCAFE, 1'b0, 8'h00, rd, lat);
    access(1'b1, 1'b0, 16'h0123, 16'h0000, 1'b0, 8'h00, rd, lat);
    chk("ws0_ram_read", rd, 16'hCAFE);
    chk("ws0_latency_ram", lat, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
